// File: rtl/inst_queue_if.sv
// Fetch-to-decode instruction queue bundle: icache push side, decode pop side, flush and status.
// master drives fetch/decode/flush inputs; slave is the queue itself.
interface inst_queue_if #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
);
  logic                       icache_iq_valid;
  logic [ADDR_W-1:0]          icache_iq_pc;
  logic [127:0]               icache_iq_insn;
  logic                       icache_iq_delot_en;
  logic                       iq_allin;
  logic                       id_allin;
  logic                       iq_id_valid0;
  logic                       iq_id_valid1;
  logic [31:0]                iq_id_insn0;
  logic [31:0]                iq_id_insn1;
  logic [ADDR_W-1:0]          iq_id_pc0;
  logic [ADDR_W-1:0]          iq_id_pc1;
  logic                       flush;
  logic [$clog2(DEPTH):0]     iq_count;

  modport slave (
    input  icache_iq_valid, icache_iq_pc, icache_iq_insn, icache_iq_delot_en,
    input  id_allin, flush,
    output iq_allin, iq_id_valid0, iq_id_valid1, iq_id_insn0, iq_id_insn1,
    output iq_id_pc0, iq_id_pc1, iq_count
  );

  modport master (
    output icache_iq_valid, icache_iq_pc, icache_iq_insn, icache_iq_delot_en,
    output id_allin, flush,
    input  iq_allin, iq_id_valid0, iq_id_valid1, iq_id_insn0, iq_id_insn1,
    input  iq_id_pc0, iq_id_pc1, iq_count
  );
endinterface

// File: rtl/inst_queue.sv
// Circular instruction queue: up to 4 pushes and 2 first-word-fall-through pops per cycle.
// Push accepted only while 4 entries are free; flush empties the queue, reset beats flush.
module inst_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input logic          clk,
  input logic          rst_,
  inst_queue_if.slave  iq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]       insn_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [2:0]       n_in;
  logic [1:0]       n_out;
  logic             push;
  logic             valid0, valid1;
  logic [PTR_W-1:0] head_p1;

  // Group size follows the fetch PC increment: a group ends at the 16-byte boundary.
  always_comb begin
    n_in = 3'd1;
    if (!iq.icache_iq_delot_en) begin
      n_in = 3'd4 - {1'b0, iq.icache_iq_pc[3:2]};
    end
  end

  assign iq.iq_allin = (count_q <= CNT_W'(DEPTH - 4));
  assign push        = iq.icache_iq_valid && iq.iq_allin && !iq.flush;
  assign valid0      = (count_q != '0);
  assign valid1      = (count_q > CNT_W'(1));

  always_comb begin
    n_out = 2'd0;
    if (iq.id_allin && !iq.flush) begin
      n_out = {1'b0, valid0} + {1'b0, valid1};
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (iq.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(n_out);
      if (push) begin
        tail_d = tail_q + PTR_W'(n_in);
      end
      count_d = count_q + (push ? CNT_W'(n_in) : '0) - CNT_W'(n_out);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is intentionally not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < n_in) begin
          insn_q[tail_q + PTR_W'(i)] <= iq.icache_iq_insn[32*i +: 32];
          pc_q[tail_q + PTR_W'(i)]   <= iq.icache_iq_pc + ADDR_W'(4 * i);
        end
      end
    end
  end

  assign head_p1         = head_q + PTR_W'(1);
  assign iq.iq_id_valid0 = valid0;
  assign iq.iq_id_valid1 = valid1;
  assign iq.iq_id_insn0  = insn_q[head_q];
  assign iq.iq_id_insn1  = insn_q[head_p1];
  assign iq.iq_id_pc0    = pc_q[head_q];
  assign iq.iq_id_pc1    = pc_q[head_p1];
  assign iq.iq_count     = count_q;
endmodule

// File: tb/tb_inst_queue.sv
// Directed plus randomized bench for inst_queue, checked against a queue-based program-order model.
module tb_inst_queue;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst_;
  int   n_assert = 0;
  int   n_fail   = 0;
  bit   model_ok = 0;

  logic [31:0] mq_insn[$];
  logic [31:0] mq_pc[$];

  always #5 clk = ~clk;

  inst_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) iq ();

  inst_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .iq   (iq)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_allin();
    return (DEPTH - mq_pc.size()) >= 4;
  endfunction

  task automatic check_model();
    int sz;
    sz = mq_pc.size();
    chk("m_count", 64'(iq.iq_count), 64'(sz));
    chk("m_allin", 64'(iq.iq_allin), 64'(model_allin()));
    chk("m_v0", 64'(iq.iq_id_valid0), 64'(sz >= 1));
    chk("m_v1", 64'(iq.iq_id_valid1), 64'(sz >= 2));
    if (sz >= 1) begin
      chk("m_insn0", 64'(iq.iq_id_insn0), 64'(mq_insn[0]));
      chk("m_pc0", 64'(iq.iq_id_pc0), 64'(mq_pc[0]));
    end
    if (sz >= 2) begin
      chk("m_insn1", 64'(iq.iq_id_insn1), 64'(mq_insn[1]));
      chk("m_pc1", 64'(iq.iq_id_pc1), 64'(mq_pc[1]));
    end
  endtask

  // Check current outputs against the model, advance the model by the driven inputs, clock once.
  task automatic cycle();
    int sz, npop, n;
    if (model_ok) check_model();
    sz = mq_pc.size();
    if (rst_ || iq.flush) begin
      mq_insn.delete();
      mq_pc.delete();
    end else begin
      npop = iq.id_allin ? ((sz >= 2) ? 2 : sz) : 0;
      if (iq.icache_iq_valid && model_allin()) begin
        n = iq.icache_iq_delot_en ? 1 : 4 - int'(iq.icache_iq_pc[3:2]);
        for (int i = 0; i < n; i++) begin
          mq_insn.push_back(iq.icache_iq_insn[32*i +: 32]);
          mq_pc.push_back(iq.icache_iq_pc + 32'(4 * i));
        end
      end
      repeat (npop) begin
        void'(mq_insn.pop_front());
        void'(mq_pc.pop_front());
      end
    end
    if (rst_) model_ok = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic dl, input logic pop, input logic fl);
    iq.icache_iq_valid    = v;
    iq.icache_iq_pc       = pc;
    iq.icache_iq_delot_en = dl;
    iq.id_allin           = pop;
    iq.flush              = fl;
    iq.icache_iq_insn     = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    logic [31:0] lane0;
    logic [31:0] grp_pc;
    logic [31:0] seq_exp;
    bit          acc;

    rst_ = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    rst_ = 1'b0;
    chk("rst_v0", 64'(iq.iq_id_valid0), 64'd0);
    chk("rst_v1", 64'(iq.iq_id_valid1), 64'd0);
    chk("rst_count", 64'(iq.iq_count), 64'd0);
    chk("rst_allin", 64'(iq.iq_allin), 64'd1);

    // Aligned 4-wide group into an empty queue
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    iq.icache_iq_insn = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("g4_v0", 64'(iq.iq_id_valid0), 64'd1);
    chk("g4_v1", 64'(iq.iq_id_valid1), 64'd1);
    chk("g4_insn0", 64'(iq.iq_id_insn0), 64'hAAAA_0000);
    chk("g4_pc0", 64'(iq.iq_id_pc0), 64'h0);
    chk("g4_insn1", 64'(iq.iq_id_insn1), 64'hBBBB_0001);
    chk("g4_pc1", 64'(iq.iq_id_pc1), 64'h4);
    chk("g4_count", 64'(iq.iq_count), 64'd4);

    // Unaligned single and delay-slot groups
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 32'h1C, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("off3_count", 64'(iq.iq_count), 64'd1);
    drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
    lane0 = iq.icache_iq_insn[31:0];
    cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("dly_count", 64'(iq.iq_count), 64'd2);
    chk("dly_pc1", 64'(iq.iq_id_pc1), 64'h40);
    chk("dly_insn1", 64'(iq.iq_id_insn1), 64'(lane0));

    // Fill to 13: iq_allin drops, held group not written, one pop reopens
    drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h110, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h124, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("fill_count", 64'(iq.iq_count), 64'd13);
    chk("fill_allin", 64'(iq.iq_allin), 64'd0);
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("held_count", 64'(iq.iq_count), 64'd13);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle();
    chk("pop2_count", 64'(iq.iq_count), 64'd11);
    chk("pop2_allin", 64'(iq.iq_allin), 64'd1);

    // Streaming with wrap-around: popped PCs must step by exactly 4
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle();
    grp_pc  = 32'h1000;
    seq_exp = 32'h1000;
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, grp_pc, 1'b0, 1'b1, 1'b0);
      if (iq.iq_id_valid0) begin
        chk("seq_pc0", 64'(iq.iq_id_pc0), 64'(seq_exp));
        seq_exp += 32'd4;
      end
      if (iq.iq_id_valid1) begin
        chk("seq_pc1", 64'(iq.iq_id_pc1), 64'(seq_exp));
        seq_exp += 32'd4;
      end
      acc = model_allin();
      cycle();
      if (acc) grp_pc += 32'd16;
    end
    chk("seq_wrapped", 64'(seq_exp > 32'h1040), 64'd1);

    // Flush beats a simultaneous push and pop
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h310, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h32C, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("pre_fl_count", 64'(iq.iq_count), 64'd9);
    drive(1'b1, 32'h400, 1'b0, 1'b1, 1'b1);
    cycle();
    chk("fl_count", 64'(iq.iq_count), 64'd0);
    chk("fl_v0", 64'(iq.iq_id_valid0), 64'd0);
    chk("fl_allin", 64'(iq.iq_allin), 64'd1);
    drive(1'b1, 32'hBFC0_0380, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("exc_v0", 64'(iq.iq_id_valid0), 64'd1);
    chk("exc_pc0", 64'(iq.iq_id_pc0), 64'hBFC0_0380);

    // Single entry pop without underflow
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 32'h50C, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("one_v0", 64'(iq.iq_id_valid0), 64'd1);
    chk("one_v1", 64'(iq.iq_id_valid1), 64'd0);
    cycle();
    chk("one_count", 64'(iq.iq_count), 64'd0);
    cycle();
    chk("empty_count", 64'(iq.iq_count), 64'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 9) < 7), $urandom, 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0));
      rst_ = 1'($urandom_range(0, 99) == 0);
      cycle();
    end
    rst_ = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
